// File: rtl/minmax_pkg.sv
// -----------------------------------------------------------------------------
// minmax_pkg
// Shared definitions for the running min/max tracker:
//   - output select encodings (last / min / max / range)
//   - tracker state enumeration
// -----------------------------------------------------------------------------
package minmax_pkg;

    // Output select bus width and encodings
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_LAST  = 2'd0;
    localparam logic [SEL_W-1:0] SEL_MIN   = 2'd1;
    localparam logic [SEL_W-1:0] SEL_MAX   = 2'd2;
    localparam logic [SEL_W-1:0] SEL_RANGE = 2'd3;

    // Tracker state: EMPTY means no sample accepted since clear/reset
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

endpackage : minmax_pkg

// File: rtl/minmax_cmp.sv
// -----------------------------------------------------------------------------
// minmax_cmp
// Parametrised magnitude comparator producing strict less-than / greater-than
// flags for a against b. Signedness is fixed at elaboration time.
//
// Parameters:
//   WIDTH   operand width in bits
//   SIGNED  1 = two's-complement compare, 0 = unsigned compare
// Ports:
//   a     in   WIDTH  left operand
//   b     in   WIDTH  right operand
//   lt_c  out  1      a <  b (combinational)
//   gt_c  out  1      a >  b (combinational)
// -----------------------------------------------------------------------------
module minmax_cmp #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt_c,
    output logic             gt_c
);

    generate
        if (SIGNED != 0) begin : g_signed
            // Two's-complement compare
            assign lt_c = ($signed(a) < $signed(b));
            assign gt_c = ($signed(a) > $signed(b));
        end else begin : g_unsigned
            // Plain magnitude compare
            assign lt_c = (a < b);
            assign gt_c = (a > b);
        end
    endgenerate

endmodule : minmax_cmp

// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
// Running minimum / maximum tracker over a stream of WIDTH-bit samples.
// Keeps the last sample, running min, running max, a saturating sample count
// and an empty flag, and presents one selected statistic on a registered port.
//
// Build option:
//   MINMAX_RANGE_EN  when defined, sel=3 returns (max - min) mod 2^WIDTH;
//                    when undefined, no subtractor is built and sel=3 aliases
//                    sel=2 (max).
//
// Parameters:
//   WIDTH    sample width in bits (>= 2)
//   COUNT_W  sample counter width; counter saturates at all-ones
//   SIGNED   1 = two's-complement compares, 0 = unsigned compares
// Ports:
//   clock      in   1        sole clock, rising edge
//   reset_n    in   1        synchronous active-low reset
//   clear      in   1        discard history; tracker becomes empty
//   in_valid   in   1        in_data carries a sample this cycle
//   in_data    in   WIDTH    sample value
//   sel        in   2        output select: 0 last, 1 min, 2 max, 3 range
//   out_valid  out  1        out_data meaningful (registered)
//   out_data   out  WIDTH    selected statistic (registered)
//   count      out  COUNT_W  samples accepted since clear/reset, saturating
//   empty      out  1        no sample accepted since clear/reset
// -----------------------------------------------------------------------------
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned COUNT_W = 8,
    parameter int unsigned SIGNED  = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] count,
    output logic               empty
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // State registers and their next-state values
    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   last_q,      last_d;
    logic [WIDTH-1:0]   min_q,       min_d;
    logic [WIDTH-1:0]   max_q,       max_d;
    logic [COUNT_W-1:0] count_q,     count_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;

    // Comparator flags and selected statistic
    logic               min_lt_c;
    logic               min_gt_c;
    logic               max_lt_c;
    logic               max_gt_c;
    logic [WIDTH-1:0]   stat_c;

    // Only "below min" and "above max" steer updates; the other flags are spare
    logic [1:0]         unused_cmp_c;
    assign unused_cmp_c = {min_gt_c, max_lt_c};

    // Incoming sample against running minimum
    minmax_cmp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp_min (
        .a    (in_data),
        .b    (min_q),
        .lt_c (min_lt_c),
        .gt_c (min_gt_c)
    );

    // Incoming sample against running maximum
    minmax_cmp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp_max (
        .a    (in_data),
        .b    (max_q),
        .lt_c (max_lt_c),
        .gt_c (max_gt_c)
    );

    // Next-state logic: clear has priority, a coincident sample starts a new history
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;

        if (clear) begin
            // History discarded; last/min/max held but no longer valid
            state_d = ST_EMPTY;
            count_d = '0;
            if (in_valid) begin
                state_d = ST_TRACK;
                last_d  = in_data;
                min_d   = in_data;
                max_d   = in_data;
                count_d = COUNT_W'(1);
            end
        end else if (in_valid) begin
            case (state_q)
                ST_EMPTY: begin
                    // First sample seeds every statistic
                    state_d = ST_TRACK;
                    last_d  = in_data;
                    min_d   = in_data;
                    max_d   = in_data;
                    count_d = COUNT_W'(1);
                end
                ST_TRACK: begin
                    // Strict compares: equal samples leave min/max untouched
                    last_d = in_data;
                    if (min_lt_c) begin
                        min_d = in_data;
                    end
                    if (max_gt_c) begin
                        max_d = in_data;
                    end
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Statistic selection from the current (post-edge) state
    always_comb begin
        stat_c = last_q;
        case (sel)
            SEL_LAST:  stat_c = last_q;
            SEL_MIN:   stat_c = min_q;
            SEL_MAX:   stat_c = max_q;
`ifdef MINMAX_RANGE_EN
            // Wraps modulo 2^WIDTH; exact as an unsigned difference in signed mode
            SEL_RANGE: stat_c = WIDTH'(max_q - min_q);
`else
            SEL_RANGE: stat_c = max_q;
`endif
            default:   stat_c = last_q;
        endcase
    end

    // Output register inputs: hold data while empty
    always_comb begin
        out_valid_d = (state_q == ST_TRACK);
        out_data_d  = out_data_q;
        if (state_q == ST_TRACK) begin
            out_data_d = stat_c;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            last_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            min_q       <= min_d;
            max_q       <= max_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Counter and empty flag are direct register reads
    assign count     = count_q;
    assign empty     = (state_q == ST_EMPTY);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule : minmax_tracker

// File: tb/tb_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmax_tracker
// Directed bench for minmax_tracker. Two instances share one stimulus stream:
//   dut_u  WIDTH=4, COUNT_W=3, SIGNED=0 (main table, saturation, reset)
//   dut_s  WIDTH=4, COUNT_W=8, SIGNED=1 (two's-complement ordering)
// Expected range results follow MINMAX_RANGE_EN.
// -----------------------------------------------------------------------------
module tb_minmax_tracker;

    logic       clock;
    logic       reset_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic [1:0] sel;

    logic       u_out_valid;
    logic [3:0] u_out_data;
    logic [2:0] u_count;
    logic       u_empty;

    logic       s_out_valid;
    logic [3:0] s_out_data;
    logic [7:0] s_count;
    logic       s_empty;

    int total;
    int bad;

`ifdef MINMAX_RANGE_EN
    localparam logic [3:0] EXP_RANGE_U  = 4'd7;   // 9 - 2
    localparam logic [3:0] EXP_RANGE_S  = 4'hF;   // 7 - (-8)
    localparam logic [3:0] EXP_RANGE_U2 = 4'd5;   // 8 - 3 unsigned
`else
    localparam logic [3:0] EXP_RANGE_U  = 4'd9;
    localparam logic [3:0] EXP_RANGE_S  = 4'd7;
    localparam logic [3:0] EXP_RANGE_U2 = 4'd8;
`endif

    minmax_tracker #(
        .WIDTH   (4),
        .COUNT_W (3),
        .SIGNED  (0)
    ) dut_u (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (u_out_valid),
        .out_data  (u_out_data),
        .count     (u_count),
        .empty     (u_empty)
    );

    minmax_tracker #(
        .WIDTH   (4),
        .COUNT_W (8),
        .SIGNED  (1)
    ) dut_s (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .count     (s_count),
        .empty     (s_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Vector: inputs applied before an edge, outputs checked 1 time unit after it
    typedef struct packed {
        logic       clr;
        logic       vld;
        logic [3:0] data;
        logic [1:0] sel;
        logic       exp_valid;
        logic [3:0] exp_data;
        logic [2:0] exp_count;
        logic       exp_empty;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic c, input logic v, input logic [3:0] d, input logic [1:0] s);
        clear    = c;
        in_valid = v;
        in_data  = d;
        sel      = s;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //             clr   vld   data   sel   valid  data   cnt   empty
        vecs[0]  = '{1'b0, 1'b1, 4'd5,  2'd1, 1'b0, 4'd0,  3'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0,  2'd1, 1'b1, 4'd5,  3'd1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'd2,  2'd2, 1'b1, 4'd5,  3'd2, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'd9,  2'd1, 1'b1, 4'd2,  3'd3, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'd9,  2'd0, 1'b1, 4'd9,  3'd4, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'd2,  2'd2, 1'b1, 4'd9,  3'd5, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'd7,  2'd0, 1'b1, 4'd2,  3'd6, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  2'd1, 1'b1, 4'd2,  3'd6, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  2'd2, 1'b1, 4'd9,  3'd6, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  2'd0, 1'b1, 4'd7,  3'd6, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  2'd3, 1'b1, EXP_RANGE_U, 3'd6, 1'b0};
        // clear together with a sample: sample starts a fresh history
        vecs[11] = '{1'b1, 1'b1, 4'd12, 2'd1, 1'b1, 4'd2,  3'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  2'd1, 1'b1, 4'd12, 3'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'd0,  2'd2, 1'b1, 4'd12, 3'd1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'd0,  2'd0, 1'b1, 4'd12, 3'd1, 1'b0};
        // clear alone, then an idle cycle: output invalid, data held
        vecs[15] = '{1'b1, 1'b0, 4'd0,  2'd0, 1'b1, 4'd12, 3'd0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 4'd0,  2'd0, 1'b0, 4'd12, 3'd0, 1'b1};

        // Reset held for two cycles
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 2'd0);
        step();
        step();
        chk("reset out_valid", 32'(u_out_valid), 32'd0);
        chk("reset out_data",  32'(u_out_data),  32'd0);
        chk("reset count",     32'(u_count),     32'd0);
        chk("reset empty",     32'(u_empty),     32'd1);
        chk("reset s_empty",   32'(s_empty),     32'd1);
        reset_n = 1'b1;

        // Table: first sample, tracking stream, range, clear collision, clear alone
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].data, vecs[i].sel);
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(u_out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d out_data", i),  32'(u_out_data),  32'(vecs[i].exp_data));
            chk($sformatf("vec%0d count", i),     32'(u_count),     32'(vecs[i].exp_count));
            chk($sformatf("vec%0d empty", i),     32'(u_empty),     32'(vecs[i].exp_empty));
        end

        // Saturation: 10 samples 3..12 with a 3-bit counter
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 4'(3 + i), 2'd0);
            step();
            chk($sformatf("sat%0d count", i), 32'(u_count), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
            if (i > 0) begin
                chk($sformatf("sat%0d last", i), 32'(u_out_data), 32'(3 + i - 1));
            end
        end
        drive(1'b0, 1'b0, 4'd0, 2'd1);
        step();
        chk("sat min", 32'(u_out_data), 32'd3);
        drive(1'b0, 1'b0, 4'd0, 2'd2);
        step();
        chk("sat max",       32'(u_out_data), 32'd12);
        chk("sat count hold", 32'(u_count),   32'd7);

        // Mid-stream reset overrides a concurrent sample
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 4'd6, 2'd2);
        step();
        chk("midrst count",     32'(u_count),     32'd0);
        chk("midrst empty",     32'(u_empty),     32'd1);
        chk("midrst out_valid", 32'(u_out_valid), 32'd0);
        chk("midrst out_data",  32'(u_out_data),  32'd0);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 2'd0);
        step();
        chk("postrst out_valid", 32'(u_out_valid), 32'd0);

        // Signed ordering: stream 3, -8, 7
        drive(1'b0, 1'b1, 4'd3, 2'd0);
        step();
        drive(1'b0, 1'b1, 4'h8, 2'd0);
        step();
        drive(1'b0, 1'b1, 4'd7, 2'd0);
        step();
        chk("signed count", 32'(s_count), 32'd3);
        chk("signed empty", 32'(s_empty), 32'd0);
        drive(1'b0, 1'b0, 4'd0, 2'd1);
        step();
        chk("signed min",   32'(s_out_data), 32'h8);
        chk("unsigned min", 32'(u_out_data), 32'd3);
        drive(1'b0, 1'b0, 4'd0, 2'd2);
        step();
        chk("signed max",   32'(s_out_data), 32'd7);
        chk("unsigned max", 32'(u_out_data), 32'd8);
        drive(1'b0, 1'b0, 4'd0, 2'd3);
        step();
        chk("signed range",   32'(s_out_data),  32'(EXP_RANGE_S));
        chk("unsigned range", 32'(u_out_data),  32'(EXP_RANGE_U2));
        chk("signed valid",   32'(s_out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_minmax_tracker
